// File: rtl/rx_fifo_if.sv
// rtl/rx_fifo_if.sv - signal bundle between the rx byte stream, the receive FIFO and its consumer
// Purpose: carries the write-side byte stream from rx and the read-side stream to the consumer.
// Signals:
//   write side : data_in[7:0], data_in_enable, data_in_start, data_in_end, error_in, fifo_full
//   read side  : data_out[7:0], data_out_valid, data_out_start, data_out_end, data_out_error, read_enable
//   status     : frame_count[ADDR_WIDTH-1:0], dropped_frames[15:0]
// Modports: master = producer/consumer side, slave = the FIFO.
interface rx_fifo_if #(
    parameter int ADDR_WIDTH = 11
);
    logic [7:0]            data_in;
    logic                  data_in_enable;
    logic                  data_in_start;
    logic                  data_in_end;
    logic                  error_in;
    logic                  fifo_full;
    logic [7:0]            data_out;
    logic                  data_out_valid;
    logic                  data_out_start;
    logic                  data_out_end;
    logic                  data_out_error;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] frame_count;
    logic [15:0]           dropped_frames;

    modport master (
        output data_in, data_in_enable, data_in_start, data_in_end, error_in, read_enable,
        input  fifo_full, data_out, data_out_valid, data_out_start, data_out_end,
               data_out_error, frame_count, dropped_frames
    );

    modport slave (
        input  data_in, data_in_enable, data_in_start, data_in_end, error_in, read_enable,
        output fifo_full, data_out, data_out_valid, data_out_start, data_out_end,
               data_out_error, frame_count, dropped_frames
    );
endinterface

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - frame-aware receive FIFO with speculative write and commit-on-end
// Purpose: buffers frames from rx, exposing a frame to the consumer only once its end byte is in.
//   Overflowed or truncated frames are rolled back and counted in dropped_frames.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high, clears all state
//   bus   : rx_fifo_if.slave (write stream, fifo_full, read stream, frame_count, dropped_frames)
// Option macro RX_FIFO_ERROR_DROP_EN: errored frames are discarded instead of being tagged
//   with data_out_error on their end byte.
module rx_fifo #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic     clock,
    input  logic     reset,
    rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

    state_t      state, state_n;
    ptr_t        wr_ptr, wr_ptr_n;
    ptr_t        commit_ptr, commit_ptr_n;
    ptr_t        rd_ptr;
    ptr_t        frame_count;
    logic [15:0] dropped_frames;
    logic        err_latch, err_latch_n;

    // entry layout: {err, end, start, data[7:0]}
    logic [10:0] mem [DEPTH];
    logic        mem_we;
    ptr_t        mem_waddr;
    logic [10:0] mem_wdata;

    logic [1:0]  drop_amt;
    logic        commit_inc;
    logic        take_start;
    logic        accept;
    logic        byte_err;
    ptr_t        wbase;

    logic [7:0]  out_data;
    logic        out_valid, out_start, out_end, out_error;
    logic        can_load;
    logic        pop_end;
    logic [16:0] drop_sum;

    assign bus.fifo_full      = (ptr_t'(wr_ptr + 1'b1) == rd_ptr);
    assign bus.data_out       = out_data;
    assign bus.data_out_valid = out_valid;
    assign bus.data_out_start = out_start;
    assign bus.data_out_end   = out_end;
    assign bus.data_out_error = out_error;
    assign bus.frame_count    = frame_count;
    assign bus.dropped_frames = dropped_frames;

    // Write side. A start byte always (re)opens a frame at commit_ptr, which rolls back
    // whatever partial frame was open; the fullness test is made against the address
    // the byte would actually land on.
    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        err_latch_n  = err_latch | ((state == FRAME) & bus.error_in);
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr;
        mem_wdata    = '0;
        drop_amt     = 2'd0;
        commit_inc   = 1'b0;

        take_start = bus.data_in_enable & bus.data_in_start;
        accept     = take_start | (bus.data_in_enable & (state == FRAME));
        wbase      = take_start ? commit_ptr : wr_ptr;
        byte_err   = take_start ? bus.error_in : (err_latch | bus.error_in);

        // a start outside IDLE abandons the frame that was open (or being discarded)
        if (take_start && state != IDLE) begin
            drop_amt = 2'd1;
        end

        if (accept) begin
            err_latch_n = byte_err;
            if (ptr_t'(wbase + 1'b1) == rd_ptr) begin
                wr_ptr_n = commit_ptr;
                if (bus.data_in_end) begin
                    drop_amt = drop_amt + 2'd1;
                    state_n  = IDLE;
                end else begin
                    state_n  = DISCARD;
                end
            end
`ifdef RX_FIFO_ERROR_DROP_EN
            else if (bus.data_in_end && byte_err) begin
                wr_ptr_n = commit_ptr;
                drop_amt = drop_amt + 2'd1;
                state_n  = IDLE;
            end
`endif
            else begin
                mem_we    = 1'b1;
                mem_waddr = wbase;
                mem_wdata = {byte_err & bus.data_in_end, bus.data_in_end, take_start, bus.data_in};
                wr_ptr_n  = ptr_t'(wbase + 1'b1);
                if (bus.data_in_end) begin
                    commit_ptr_n = ptr_t'(wbase + 1'b1);
                    commit_inc   = 1'b1;
                    state_n      = IDLE;
                end else begin
                    state_n      = FRAME;
                end
            end
        end else if (bus.data_in_enable && bus.data_in_end && state == DISCARD) begin
            drop_amt = 2'd1;
            state_n  = IDLE;
        end
    end

    assign can_load = (rd_ptr != commit_ptr) && (!out_valid || bus.read_enable);
    assign pop_end  = out_valid & bus.read_enable & out_end;
    assign drop_sum = 17'(dropped_frames) + 17'(drop_amt);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            err_latch      <= 1'b0;
            frame_count    <= '0;
            dropped_frames <= '0;
        end else begin
            state          <= state_n;
            wr_ptr         <= wr_ptr_n;
            commit_ptr     <= commit_ptr_n;
            err_latch      <= err_latch_n;
            // simultaneous commit and end-pop cancel out
            frame_count    <= frame_count + ptr_t'(commit_inc) - ptr_t'(pop_end);
            dropped_frames <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Read side: a one-entry output register fed from committed storage only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_end   <= 1'b0;
            out_error <= 1'b0;
        end else if (can_load) begin
            {out_error, out_end, out_start, out_data} <= mem[rd_ptr];
            out_valid <= 1'b1;
            rd_ptr    <= ptr_t'(rd_ptr + 1'b1);
        end else if (bus.read_enable) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - self-checking scoreboard bench for rx_fifo
module tb_rx_fifo;
    localparam int AW  = 7;
    localparam int CAP = (1 << AW) - 1;
`ifdef RX_FIFO_ERROR_DROP_EN
    localparam bit DROP_ERR = 1'b1;
`else
    localparam bit DROP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       start;
        logic       fin;
        logic       err;
    } beat_t;
    typedef logic [7:0] byte_q_t [$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rx_fifo_if #(.ADDR_WIDTH(AW)) bus ();
    rx_fifo #(.ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

    beat_t exp_q[$];
    int    checks          = 0;
    int    passed          = 0;
    int    exp_drops       = 0;
    int    committed_bytes = 0;
    int    pops            = 0;
    int    rd_mode         = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // consumer: 0 = never read, 1 = always read, 2 = random reads
    always @(posedge clock) begin
        #1;
        case (rd_mode)
            0:       bus.read_enable = 1'b0;
            1:       bus.read_enable = 1'b1;
            default: bus.read_enable = ($urandom_range(0, 3) != 0);
        endcase
    end

    // monitor: every pop the DUT performs must match the head of the expected stream
    always @(negedge clock) begin
        if (!reset && bus.data_out_valid && bus.read_enable) begin
            beat_t act;
            act = {bus.data_out, bus.data_out_start, bus.data_out_end, bus.data_out_error};
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pop: got %0h expected no output", act);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("data_out", 32'(act), 32'(e));
            end
        end
    end

    task automatic drive(input logic en, input logic [7:0] d, input logic s, input logic e, input logic er);
        @(posedge clock);
        #1;
        bus.data_in_enable = en;
        bus.data_in        = d;
        bus.data_in_start  = s;
        bus.data_in_end    = e;
        bus.error_in       = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference: a complete frame is delivered verbatim unless it is errored under
    // the drop option; an unterminated frame is dropped when the next one opens.
    task automatic send_frame(input byte_q_t bytes, input int err_at, input bit complete, input int gap_pct);
        beat_t tmp[$];
        bit    err = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            bit last;
            bit pe;
            last = complete && (i == bytes.size() - 1);
            pe   = (i == err_at);
            if (pe) err = 1'b1;
            drive(1'b1, bytes[i], i == 0, last, pe);
            tmp.push_back({bytes[i], i == 0, last, last & err});
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
        end
        if (!complete || (err && DROP_ERR)) begin
            exp_drops++;
        end else begin
            foreach (tmp[k]) exp_q.push_back(tmp[k]);
            committed_bytes += bytes.size();
        end
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        idle(3);
        while ((exp_q.size() != 0 || bus.data_out_valid) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_frame_count"}, bus.frame_count, 0);
        check({name, "_dropped"}, bus.dropped_frames, exp_drops);
    endtask

    task automatic wait_room(input int len);
        int n = 0;
        while (exp_q.size() + len + 2 > CAP && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) check("wait_room_timeout", n, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        byte_q_t b;
        int      p0;
        bus.data_in_enable = 1'b0;
        bus.data_in        = 8'h00;
        bus.data_in_start  = 1'b0;
        bus.data_in_end    = 1'b0;
        bus.error_in       = 1'b0;
        bus.read_enable    = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        check("rst_valid", bus.data_out_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_full", bus.fifo_full, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_dropped", bus.dropped_frames, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // preamble + SFD + 96 payload bytes, consumer always reading
        rd_mode = 1;
        b = {};
        repeat (7) b.push_back(8'h55);
        b.push_back(8'hD5);
        b = {b, rand_bytes(96)};
        p0 = pops;
        send_frame(b, -1, 1'b1, 0);
        idle(1);
        @(negedge clock);
        check("commit_frame_count", bus.frame_count, 1);
        drain("long");
        check("long_pop_count", pops - p0, 104);

        // error pulse mid-frame
        send_frame(rand_bytes(20), 10, 1'b1, 0);
        drain("error");

        // overflow: empty FIFO, no reads, frame longer than capacity
        rd_mode = 0;
        for (int i = 0; i < CAP + 5; i++) begin
            drive(1'b1, 8'(i), i == 0, i == CAP + 4, 1'b0);
            @(negedge clock);
            if (i == CAP - 1) check("full_below_cap", bus.fifo_full, 0);
            if (i == CAP)     check("full_at_cap", bus.fifo_full, 1);
            if (i == CAP + 1) check("full_after_rollback", bus.fifo_full, 0);
        end
        exp_drops++;
        idle(1);
        @(negedge clock);
        check("overflow_valid", bus.data_out_valid, 0);
        check("overflow_wr_ptr", 32'(dut.wr_ptr), committed_bytes % (1 << AW));
        check("overflow_dropped", bus.dropped_frames, exp_drops);
        rd_mode = 1;
        send_frame(rand_bytes(3), -1, 1'b1, 0);
        drain("after_overflow");

        // start arriving inside an open frame
        send_frame(rand_bytes(5), -1, 1'b0, 0);
        send_frame(rand_bytes(8), -1, 1'b1, 0);
        drain("restart");

        // randomized frames with random reads, gaps, errors and truncations
        rd_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len;
            int err_at;
            bit complete;
            len      = $urandom_range(1, 20);
            complete = ($urandom_range(0, 19) != 0);
            err_at   = (len > 1 && $urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : -1;
            wait_room(len);
            send_frame(rand_bytes(len), err_at, complete, 20);
            idle($urandom_range(0, 3));
        end
        send_frame(rand_bytes(6), -1, 1'b1, 0);
        drain("random");

        // reset while output is valid and a frame is open
        rd_mode = 0;
        send_frame(rand_bytes(4), -1, 1'b1, 0);
        idle(3);
        send_frame(rand_bytes(3), -1, 1'b0, 0);
        @(negedge clock);
        check("pre_reset_valid", bus.data_out_valid, 1);
        reset = 1'b1;
        bus.data_in_enable = 1'b0;
        #1;
        check("mid_rst_valid", bus.data_out_valid, 0);
        check("mid_rst_data", bus.data_out, 0);
        check("mid_rst_frame_count", bus.frame_count, 0);
        check("mid_rst_dropped", bus.dropped_frames, 0);
        exp_q.delete();
        exp_drops       = 0;
        committed_bytes = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        rd_mode = 1;
        send_frame(rand_bytes(5), -1, 1'b1, 0);
        drain("post_reset");
        check("post_reset_wr_ptr", 32'(dut.wr_ptr), committed_bytes % (1 << AW));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
